// File: rtl/wload_pkg.sv
// Shared types and latency constants for the weight-load transmitter.
package wload_pkg;

  localparam int unsigned ByteWidth   = 8;
  localparam int unsigned RdLatency   = 1;
  localparam int unsigned OutLatency  = 1;
  localparam int unsigned DrainCycles = RdLatency + OutLatency;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StDrain,
    StWaitSet,
    StCommit
  } wload_state_e;

endpackage

// File: rtl/wload_addr_gen.sv
// Weight-buffer read address generator: loadable modulo-wrapping address counter
// plus remaining-row down-counter; flags the final read of a load.
module wload_addr_gen #(
  parameter int unsigned AddrWidth = 15,
  parameter int unsigned CntWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [AddrWidth-1:0] base_i,
  input  logic [CntWidth-1:0]  count_i,
  output logic                 rd_en_o,
  output logic [AddrWidth-1:0] rd_addr_o,
  output logic                 last_o
);

  logic                 rd_en_q;
  logic [AddrWidth-1:0] addr_q;
  logic [CntWidth-1:0]  remain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
    end else if (load_i) begin
      rd_en_q  <= (count_i != '0);
      addr_q   <= base_i;
      remain_q <= count_i;
    end else if (rd_en_q) begin
      if (remain_q == CntWidth'(1)) begin
        rd_en_q <= 1'b0;
      end else begin
        // Natural-width add gives the modulo 2^AddrWidth wrap.
        addr_q   <= addr_q + AddrWidth'(1);
        remain_q <= remain_q - CntWidth'(1);
      end
    end
  end

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = addr_q;
  assign last_o    = rd_en_q && (remain_q == CntWidth'(1));

endmodule

// File: rtl/weight_load_ctrl.sv
// Weight-load transmitter: streams buffer rows into the array load-weight chains, then commits.
// Define WLOAD_BANK_TOGGLE_EN for double-buffered planes with o_bank alternating per commit.
module weight_load_ctrl
  import wload_pkg::*;
#(
  parameter int unsigned NUM_LANES         = 4,
  parameter int unsigned BUFFER_ADDR_WIDTH = 15,
  parameter int unsigned ROW_CNT_WIDTH     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start_valid,
  output logic                           o_start_ready,
  input  logic [BUFFER_ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [ROW_CNT_WIDTH-1:0]       i_num_rows,
  output logic                           o_buf_rd_en,
  output logic [BUFFER_ADDR_WIDTH-1:0]   o_buf_rd_addr,
  input  logic [ByteWidth*NUM_LANES-1:0] i_buf_rd_data,
  output logic [ByteWidth*NUM_LANES-1:0] o_load_weight_data_0,
  output logic [ByteWidth*NUM_LANES-1:0] o_load_weight_data_1,
  output logic                           o_prepare_weight,
  input  logic                           i_set_allow,
  output logic                           o_set_weight,
  output logic                           o_bank,
  output logic                           o_done
);

  localparam int unsigned DataWidth = ByteWidth * NUM_LANES;

  wload_state_e state_q;
  logic         start_ready_q;
  logic         set_q;
  logic         done_q;
  logic [1:0]   drain_cnt_q;
  logic         accept;
  logic         rd_en;
  logic         last_rd;
  logic         bank;

  logic                 rd_vld_q;
  logic                 prep_q;
  logic [DataWidth-1:0] data0_q;

  // start_ready_q is only ever high in StIdle/StCommit.
  assign accept = i_start_valid && start_ready_q;

  wload_addr_gen #(
    .AddrWidth(BUFFER_ADDR_WIDTH),
    .CntWidth (ROW_CNT_WIDTH)
  ) u_addr_gen (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (accept),
    .base_i   (i_base_addr),
    .count_i  (i_num_rows),
    .rd_en_o  (rd_en),
    .rd_addr_o(o_buf_rd_addr),
    .last_o   (last_rd)
  );

`ifdef WLOAD_BANK_TOGGLE_EN
  logic                 bank_q;
  logic                 nonzero_q;
  logic [DataWidth-1:0] data1_q;

  assign bank = bank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q    <= 1'b0;
      nonzero_q <= 1'b0;
    end else begin
      // Toggle uses the committed load's count before a same-cycle accept overwrites it.
      if (state_q == StCommit && nonzero_q) begin
        bank_q <= ~bank_q;
      end
      if (accept) begin
        nonzero_q <= (i_num_rows != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1_q <= '0;
    end else begin
      data1_q <= (rd_vld_q && bank) ? i_buf_rd_data : '0;
    end
  end

  assign o_load_weight_data_1 = data1_q;
`else
  assign bank                 = 1'b0;
  assign o_load_weight_data_1 = '0;
`endif

  // Read data lands one cycle after rd_en and is held for one cycle in the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      prep_q   <= 1'b0;
      data0_q  <= '0;
    end else begin
      rd_vld_q <= rd_en;
      prep_q   <= rd_vld_q;
      data0_q  <= (rd_vld_q && !bank) ? i_buf_rd_data : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      start_ready_q <= 1'b0;
      set_q         <= 1'b0;
      done_q        <= 1'b0;
      drain_cnt_q   <= '0;
    end else begin
      set_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StCommit: begin
          state_q       <= StIdle;
          start_ready_q <= 1'b1;
          if (accept) begin
            if (i_num_rows == '0) begin
              state_q <= StCommit;
              done_q  <= 1'b1;
            end else begin
              state_q       <= StShift;
              start_ready_q <= 1'b0;
            end
          end
        end
        StShift: begin
          if (last_rd) begin
            state_q     <= StDrain;
            drain_cnt_q <= '0;
          end
        end
        StDrain: begin
          if (drain_cnt_q == 2'(DrainCycles - 1)) begin
            state_q <= StWaitSet;
          end else begin
            drain_cnt_q <= drain_cnt_q + 2'd1;
          end
        end
        StWaitSet: begin
          if (i_set_allow) begin
            state_q       <= StCommit;
            set_q         <= 1'b1;
            done_q        <= 1'b1;
            start_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_start_ready        = start_ready_q;
  assign o_buf_rd_en          = rd_en;
  assign o_load_weight_data_0 = data0_q;
  assign o_prepare_weight     = prep_q;
  assign o_set_weight         = set_q;
  assign o_done               = done_q;
  assign o_bank               = bank;

endmodule
